// File: rtl/draw_scheduler_if.sv
// Request and pixel bus between a region-redraw scheduler and its clients.
// The requester/art source is the master; the scheduler is the slave.
interface draw_scheduler_if;
  logic       reqMoney;
  logic       reqSelection;
  logic       reqUpgrade;
  logic       reqBlack;
  logic [2:0] colourIn;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic [5:0] xOff;
  logic [4:0] yOff;
  logic [1:0] regionId;
  logic       busy;
  logic       done;

  modport master (
    output reqMoney, reqSelection, reqUpgrade, reqBlack, colourIn,
    input  plot, x, y, colour, xOff, yOff, regionId, busy, done
  );

  modport slave (
    input  reqMoney, reqSelection, reqUpgrade, reqBlack, colourIn,
    output plot, x, y, colour, xOff, yOff, regionId, busy, done
  );
endinterface

// File: rtl/draw_scheduler.sv
// Schedules full redraws of fixed screen regions, walking each region pixel by
// pixel and emitting VGA plot strobes; requests are latched and prioritised.
//
// state | meaning
// IDLE  | waiting; grants highest-priority pending region
// LOAD  | zero region offsets
// DRAW  | one plot per cycle across the region, row-major
// DONE  | one-cycle done pulse; a clear re-queues SELECTION
module draw_scheduler #(
  parameter logic [2:0] COLOUR_BG = 3'b000
) (
  input logic        clock,
  input logic        reset,
  draw_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  localparam logic [1:0] REGION_MONEY     = 2'd0;
  localparam logic [1:0] REGION_SELECTION = 2'd1;
  localparam logic [1:0] REGION_UPGRADE   = 2'd2;
  localparam logic [1:0] REGION_BLACK     = 2'd3;

  state_t     state, stateNext;
  logic [3:0] pending, pendingNext;
  logic [3:0] grantMask, reqVec, autoQueue;
  logic [1:0] regionId, regionIdNext;
  logic [5:0] xOff, xOffNext;
  logic [4:0] yOff, yOffNext;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [5:0] width;
  logic [4:0] height;

  always_comb begin
    x0     = 8'd8;
    y0     = 7'd8;
    width  = 6'd40;
    height = 5'd8;
    case (regionId)
      REGION_MONEY:     begin x0 = 8'd8; y0 = 7'd8;  width = 6'd40; height = 5'd8;  end
      REGION_SELECTION: begin x0 = 8'd8; y0 = 7'd24; width = 6'd16; height = 5'd16; end
      REGION_UPGRADE:   begin x0 = 8'd8; y0 = 7'd48; width = 6'd24; height = 5'd8;  end
      default:          begin x0 = 8'd8; y0 = 7'd24; width = 6'd16; height = 5'd16; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= 4'b0000;
      regionId <= REGION_MONEY;
      xOff     <= 6'd0;
      yOff     <= 5'd0;
    end else begin
      state    <= stateNext;
      pending  <= pendingNext;
      regionId <= regionIdNext;
      xOff     <= xOffNext;
      yOff     <= yOffNext;
    end
  end

  always_comb begin
    stateNext    = state;
    regionIdNext = regionId;
    xOffNext     = xOff;
    yOffNext     = yOff;
    grantMask    = 4'b0000;
    autoQueue    = 4'b0000;
    reqVec       = {bus.reqBlack, bus.reqUpgrade, bus.reqSelection, bus.reqMoney};

    case (state)
      IDLE: begin
        if (pending != 4'b0000) begin
          stateNext = LOAD;
          if (pending[3])      regionIdNext = REGION_BLACK;
          else if (pending[2]) regionIdNext = REGION_UPGRADE;
          else if (pending[1]) regionIdNext = REGION_SELECTION;
          else                 regionIdNext = REGION_MONEY;
          grantMask[regionIdNext] = 1'b1;
        end
      end
      LOAD: begin
        xOffNext  = 6'd0;
        yOffNext  = 5'd0;
        stateNext = DRAW;
      end
      DRAW: begin
        if (xOff == width - 6'd1) begin
          xOffNext = 6'd0;
          if (yOff == height - 5'd1) stateNext = DONE;
          else                       yOffNext  = yOff + 5'd1;
        end else begin
          xOffNext = xOff + 6'd1;
        end
      end
      DONE: begin
        stateNext = IDLE;
        // A cleared selection box must always be repainted.
        if (regionId == REGION_BLACK) autoQueue[REGION_SELECTION] = 1'b1;
      end
      default: stateNext = IDLE;
    endcase

    // New requests win over the grant clear, so a same-edge re-request is kept.
    pendingNext = (pending & ~grantMask) | reqVec | autoQueue;
  end

  assign bus.plot     = (state == DRAW);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.x        = x0 + {2'b00, xOff};
  assign bus.y        = y0 + {2'b00, yOff};
  assign bus.colour   = (regionId == REGION_BLACK) ? COLOUR_BG : bus.colourIn;
  assign bus.xOff     = xOff;
  assign bus.yOff     = yOff;
  assign bus.regionId = regionId;
endmodule
